// File: rtl/dec_pipe_secded.sv
// Two-stage pipelined multi-mode SECDED (extended Hamming) decoder with a valid/ready
// stream interface and saturating corrected/uncorrectable statistics counters.
module dec_pipe_secded #(
    parameter int unsigned NUM_MODES          = 3,
    parameter int unsigned MAX_CODEWORD_WIDTH = 8 << (NUM_MODES - 1),
    parameter int unsigned MAX_INFO_WIDTH     = MAX_CODEWORD_WIDTH - (3 + NUM_MODES),
    parameter int unsigned CNT_WIDTH          = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [MAX_CODEWORD_WIDTH-1:0] data_in,
    input  logic [1:0]                    mod,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [MAX_INFO_WIDTH-1:0]     data_out,
    output logic [1:0]                    num_of_errors,
    input  logic                          cnt_clr,
    output logic [CNT_WIDTH-1:0]          cnt_corrected,
    output logic [CNT_WIDTH-1:0]          cnt_uncorrectable
);

    localparam int unsigned SW = NUM_MODES + 2;
    localparam int unsigned CW = MAX_CODEWORD_WIDTH;

    // Info bit idx takes the idx-th non-power-of-two column starting at 3; this ordering
    // is the same for every mode, only the number of info bits differs.
    function automatic logic [SW-1:0] info_col(input int unsigned idx);
        logic [SW-1:0] res = '0;
        int unsigned   n   = 0;
        for (int unsigned v = 3; v < (32'd1 << SW); v++) begin
            if ((v & (v - 1)) != 0) begin
                if (n == idx) res = SW'(v);
                n++;
            end
        end
        return res;
    endfunction

    // Column of codeword bit b in mode m; the overall parity bit has no column.
    function automatic logic [SW-1:0] col_of(input int unsigned m, input int unsigned b);
        logic [SW-1:0] c = '0;
        int unsigned   p = 4 + m;
        if (b < p - 1) c = SW'(32'd1 << b);
        else if (b >= p) c = info_col(b - p);
        return c;
    endfunction

    logic                      en;
    logic                      v1_q, v1_d;
    logic [CW-1:0]             cw1_q, cw1_d;
    logic [1:0]                mode1_q, mode1_d;
    logic [SW-1:0]             s1_q, s1_d;
    logic                      p1_q, p1_d;
    logic                      v2_q, v2_d;
    logic [MAX_INFO_WIDTH-1:0] info2_q, info2_d;
    logic [1:0]                err2_q, err2_d;
    logic [CNT_WIDTH-1:0]      cc_q, cc_d;
    logic [CNT_WIDTH-1:0]      cu_q, cu_d;
    logic [CW-1:0]             corr;
    logic                      hs;

    assign en       = !v2_q || out_ready;
    assign in_ready = en;
    assign hs       = v2_q && out_ready;

    // Stage 1: mask to the selected code size, compute syndrome and overall parity.
    always_comb begin
        v1_d    = v1_q;
        cw1_d   = cw1_q;
        mode1_d = mode1_q;
        s1_d    = s1_q;
        p1_d    = p1_q;
        if (en) begin
            v1_d = in_valid;
            if (in_valid) begin
                mode1_d = mod;
                cw1_d   = '0;
                s1_d    = '0;
                p1_d    = 1'b0;
                for (int unsigned m = 0; m < NUM_MODES; m++) begin
                    if (mod == 2'(m)) begin
                        for (int unsigned b = 0; b < (32'd8 << m); b++) begin
                            cw1_d[b] = data_in[b];
                            if (data_in[b]) begin
                                p1_d = ~p1_d;
                                s1_d ^= col_of(m, b);
                            end
                        end
                    end
                end
            end
        end
    end

    // Stage 2: correct, extract info and classify. Illegal modes fall through the
    // loop untouched and keep the zero/3 defaults.
    always_comb begin
        v2_d    = v2_q;
        info2_d = info2_q;
        err2_d  = err2_q;
        corr    = '0;
        if (en) begin
            v2_d = v1_q;
            if (v1_q) begin
                info2_d = '0;
                err2_d  = 2'd3;
                for (int unsigned m = 0; m < NUM_MODES; m++) begin
                    if (mode1_q == 2'(m)) begin
                        corr = cw1_q;
                        if (p1_q && (s1_q != '0)) begin
                            for (int unsigned b = 0; b < (32'd8 << m); b++) begin
                                if (col_of(m, b) == s1_q) corr[b] = ~corr[b];
                            end
                        end
                        info2_d = MAX_INFO_WIDTH'(corr >> (4 + m));
                        err2_d  = p1_q ? 2'd1 : ((s1_q != '0) ? 2'd2 : 2'd0);
                    end
                end
            end
        end
    end

    // Clear has priority over a coincident increment.
    always_comb begin
        cc_d = cc_q;
        cu_d = cu_q;
        if (cnt_clr) begin
            cc_d = '0;
            cu_d = '0;
        end else if (hs) begin
            if ((err2_q == 2'd1) && (cc_q != '1)) cc_d = cc_q + CNT_WIDTH'(1);
            if (err2_q[1] && (cu_q != '1)) cu_d = cu_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1_q    <= 1'b0;
            cw1_q   <= '0;
            mode1_q <= '0;
            s1_q    <= '0;
            p1_q    <= 1'b0;
            v2_q    <= 1'b0;
            info2_q <= '0;
            err2_q  <= '0;
            cc_q    <= '0;
            cu_q    <= '0;
        end else begin
            v1_q    <= v1_d;
            cw1_q   <= cw1_d;
            mode1_q <= mode1_d;
            s1_q    <= s1_d;
            p1_q    <= p1_d;
            v2_q    <= v2_d;
            info2_q <= info2_d;
            err2_q  <= err2_d;
            cc_q    <= cc_d;
            cu_q    <= cu_d;
        end
    end

    assign out_valid         = v2_q;
    assign data_out          = info2_q;
    assign num_of_errors     = err2_q;
    assign cnt_corrected     = cc_q;
    assign cnt_uncorrectable = cu_q;

endmodule

// File: tb/tb_dec_pipe_secded.sv
// Bench for dec_pipe_secded: directed and injected-error words, each carrying its expected
// result, checked in order by a scoreboard on every output handshake.
module tb_dec_pipe_secded;

    localparam int CNTW = 4;
    localparam int CMAX = (1 << CNTW) - 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] data_in;
    logic [1:0]  mod;
    logic        out_valid;
    logic        out_ready;
    logic [25:0] data_out;
    logic [1:0]  num_of_errors;
    logic        cnt_clr;
    logic [3:0]  cnt_corrected;
    logic [3:0]  cnt_uncorrectable;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  md;
        logic [25:0] info;
        logic [1:0]  err;
        int          acc;
    } item_t;

    item_t       stim_q[$];
    item_t       exp_q[$];
    item_t       tmp;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          mc = 0;
    int          mu = 0;
    bit          lat_chk = 1'b1;
    bit          bp = 1'b0;
    int          rdy_idx = 0;
    bit          rdy_pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    bit          prev_stall = 1'b0;
    bit          head_seen = 1'b0;
    logic [25:0] prev_data;
    logic [1:0]  prev_err;

    always #5 clk = ~clk;

    dec_pipe_secded #(
        .NUM_MODES(3),
        .CNT_WIDTH(CNTW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .data_in          (data_in),
        .mod              (mod),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .data_out         (data_out),
        .num_of_errors    (num_of_errors),
        .cnt_clr          (cnt_clr),
        .cnt_corrected    (cnt_corrected),
        .cnt_uncorrectable(cnt_uncorrectable)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // i-th value >= 3 that is not a power of two.
    function automatic int info_col(input int i);
        int n = 0;
        for (int v = 3; v < 64; v++) begin
            if ((v & (v - 1)) != 0) begin
                if (n == i) return v;
                n++;
            end
        end
        return 0;
    endfunction

    function automatic logic [31:0] encode(input logic [25:0] info, input int m);
        int          p = 4 + m;
        int          k = (8 << m) - p;
        int          s = 0;
        logic [31:0] cw = '0;
        for (int i = 0; i < k; i++) begin
            if (info[i]) begin
                cw[p+i] = 1'b1;
                s ^= info_col(i);
            end
        end
        for (int j = 0; j < p - 1; j++) cw[j] = s[j];
        cw[p-1] = ^cw;
        return cw;
    endfunction

    task automatic push_raw(input logic [31:0] d, input logic [1:0] m, input logic [25:0] i,
                            input logic [1:0] e);
        item_t it;
        it.data = d;
        it.md   = m;
        it.info = i;
        it.err  = e;
        it.acc  = 0;
        stim_q.push_back(it);
    endtask

    // Randomise the bits above the codeword, which the decoder must ignore.
    task automatic push_word(input logic [31:0] cw, input int m, input logic [25:0] i,
                             input logic [1:0] e);
        int          n = 8 << m;
        logic [31:0] lowmask;
        logic [31:0] up;
        lowmask = (n >= 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
        up = $urandom();
        push_raw((cw & lowmask) | (up & ~lowmask), 2'(m), i, e);
    endtask

    task automatic sweep_mode(input int m);
        int          n = 8 << m;
        int          p = 4 + m;
        int          k = n - p;
        logic [31:0] kmask;
        logic [31:0] cw;
        logic [31:0] rx;
        logic [25:0] info;
        int          b1;
        int          b2;
        kmask = (32'd1 << k) - 32'd1;
        for (int r = 0; r < 3; r++) begin
            info = 26'($urandom() & kmask);
            cw = encode(info, m);
            push_word(cw, m, info, 2'd0);
            for (int b = 0; b < n; b++) push_word(cw ^ (32'd1 << b), m, info, 2'd1);
            for (int q = 0; q < 4; q++) begin
                b1 = $urandom_range(0, n - 1);
                b2 = (b1 + $urandom_range(1, n - 1)) % n;
                rx = cw ^ (32'd1 << b1) ^ (32'd1 << b2);
                push_word(rx, m, 26'((rx >> p) & kmask), 2'd2);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (bp) begin
            out_ready = rdy_pat[rdy_idx % 4];
            rdy_idx++;
        end else begin
            out_ready = 1'b1;
        end
        if (stim_q.size() > 0) begin
            in_valid = 1'b1;
            data_in  = stim_q[0].data;
            mod      = stim_q[0].md;
        end else begin
            in_valid = 1'b0;
        end
    endtask

    task automatic drain(input string tag);
        int budget = 5000;
        step();
        while ((stim_q.size() > 0 || exp_q.size() > 0) && budget > 0) begin
            step();
            budget--;
        end
        if (budget == 0) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: %0d words pending, required 0", tag,
                     stim_q.size() + exp_q.size());
        end
    endtask

    task automatic clr_cnt();
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        check("clr_cnt_corrected", cnt_corrected, 0);
        check("clr_cnt_uncorrectable", cnt_uncorrectable, 0);
    endtask

    // Scoreboard and per-cycle protocol checks.
    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            mc = 0;
            mu = 0;
            prev_stall = 1'b0;
            head_seen = 1'b0;
        end else begin
            cyc++;
            check("in_ready", in_ready, !(out_valid && !out_ready));
            check("cnt_corrected", cnt_corrected, mc);
            check("cnt_uncorrectable", cnt_uncorrectable, mu);
            if (prev_stall) begin
                check("stall_out_valid", out_valid, 1);
                check("stall_data_out", data_out, prev_data);
                check("stall_num_of_errors", num_of_errors, prev_err);
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_output: out_valid=1 data_out=%0h, required no output",
                             data_out);
                end else begin
                    if (!head_seen && lat_chk) check("latency", cyc - exp_q[0].acc, 2);
                    head_seen = 1'b1;
                    if (out_ready) begin
                        check("data_out", data_out, exp_q[0].info);
                        check("num_of_errors", num_of_errors, exp_q[0].err);
                        if (exp_q[0].err == 2'd1 && mc < CMAX) mc++;
                        if (exp_q[0].err >= 2'd2 && mu < CMAX) mu++;
                        void'(exp_q.pop_front());
                        head_seen = 1'b0;
                    end
                end
            end
            if (cnt_clr) begin
                mc = 0;
                mu = 0;
            end
            if (in_valid && in_ready && stim_q.size() > 0) begin
                tmp = stim_q.pop_front();
                tmp.acc = cyc;
                exp_q.push_back(tmp);
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = data_out;
            prev_err   = num_of_errors;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int budget;
        rst = 1'b0;
        in_valid = 1'b0;
        data_in = '0;
        mod = '0;
        out_ready = 1'b1;
        cnt_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;

        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_data_out", data_out, 0);
        check("rst_num_of_errors", num_of_errors, 0);
        check("rst_cnt_corrected", cnt_corrected, 0);
        check("rst_cnt_uncorrectable", cnt_uncorrectable, 0);
        check("model_encode_m0", encode(26'hB, 0), 32'hB1);
        check("model_encode_m1", encode(26'h1, 1), 32'h33);

        // Mode 0 directed words and illegal mode.
        push_raw(32'hB1, 2'd0, 26'hB, 2'd0);
        push_raw(32'h91, 2'd0, 26'hB, 2'd1);
        push_raw(32'hB9, 2'd0, 26'hB, 2'd1);
        push_raw(32'h81, 2'd0, 26'h8, 2'd2);
        push_raw(32'h1234_5678, 2'd3, 26'h0, 2'd3);
        drain("directed");
        check("dir_cnt_corrected", cnt_corrected, 2);
        check("dir_cnt_uncorrectable", cnt_uncorrectable, 2);

        // Injected-error sweep across all modes.
        clr_cnt();
        for (int m = 0; m < 3; m++) sweep_mode(m);
        drain("sweep");

        // Backpressure with out_ready 1,0,0,1,...
        bp = 1'b1;
        lat_chk = 1'b0;
        rdy_idx = 0;
        for (int w = 0; w < 10; w++) begin
            tmp.info = 26'($urandom() & 32'h7FF);
            tmp.data = encode(tmp.info, 1);
            if (w % 3 == 1) push_word(tmp.data ^ (32'd1 << w), 1, tmp.info, 2'd1);
            else push_word(tmp.data, 1, tmp.info, 2'd0);
        end
        drain("backpressure");
        bp = 1'b0;
        lat_chk = 1'b1;

        // Saturation of the corrected counter.
        clr_cnt();
        for (int w = 0; w < 17; w++) push_raw(32'hB1 ^ (32'd1 << (w % 8)), 2'd0, 26'hB, 2'd1);
        drain("saturate");
        check("sat_cnt_corrected", cnt_corrected, 4'hF);

        // Clear coinciding with a correctable handshake.
        push_raw(32'h91, 2'd0, 26'hB, 2'd1);
        budget = 20;
        step();
        while (!out_valid && budget > 0) begin
            step();
            budget--;
        end
        if (budget == 0) begin
            total++;
            bad++;
            $display("FAIL clr_wins_timeout: out_valid=0, required 1");
        end
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        check("clr_wins_cnt_corrected", cnt_corrected, 0);

        // Reset with two words in flight.
        push_raw(32'hB1, 2'd0, 26'hB, 2'd0);
        push_raw(32'h91, 2'd0, 26'hB, 2'd1);
        budget = 20;
        step();
        while (stim_q.size() > 0 && budget > 0) begin
            step();
            budget--;
        end
        rst = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            check("post_rst_out_valid", out_valid, 0);
        end
        check("post_rst_cnt_corrected", cnt_corrected, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
